// File: rtl/spi_slave.sv
// SPI slave for all four CPOL/CPHA modes. sclk, cs and mosi are oversampled on Pclk.
// Holds one tx word in a buffer ahead of the shift register, plus a single rx holding register.
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              Pclk,
    input  logic              Preset_n,
    input  logic [1:0]        mode,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_read,
    output logic              overrun,
    output logic              underrun,
    output logic              abort,
    output logic              busy
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    localparam int              CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, settle;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_d, cs_d, armed;
    logic                   cs_fall, cs_rise;

    logic [0:0]        state;
    logic              cpol, cpha;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_shift, rx_next;
    logic [DATA_W-1:0] tx_shift, tx_buf;
    logic              tx_full;
    logic              complete_d;

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic frame_live, sample_now, complete_now, shift_now;
    logic word_start;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // armed only goes high once a genuinely synchronized cs=1 is seen, so a cs
    // already low when reset releases cannot start a frame.
    always_ff @(posedge Pclk or negedge Preset_n) begin
        if (!Preset_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            settle    <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            armed     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop in the chain take its
            // neighbour's old value, which is what a shift/synchronizer chain needs.
            sclk_sync[0] <= sclk;
            cs_sync[0]   <= cs;
            mosi_sync[0] <= mosi;
            settle[0]    <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync[i] <= sclk_sync[i-1];
                cs_sync[i]   <= cs_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
                settle[i]    <= settle[i-1];
            end
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
            armed  <= armed | (cs_s & settle[SYNC_STAGES-1]);
        end
    end

    assign cs_fall = armed & cs_d & ~cs_s;
    assign cs_rise = ~cs_d & cs_s;

    assign lead_edge   = (sclk_s != sclk_d) && (sclk_s != cpol);
    assign trail_edge  = (sclk_s != sclk_d) && (sclk_s == cpol);
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge  : trail_edge;

    assign frame_live   = (state == ACTIVE) && !cs_rise;
    assign sample_now   = frame_live && sample_edge;
    assign complete_now = sample_now && (bit_cnt == LAST);
    // The first edge of each word must leave the freshly loaded MSB on miso.
    assign shift_now    = frame_live && shift_edge && (bit_cnt != '0);
    assign word_start   = ((state == IDLE) && cs_fall) || (frame_live && complete_d);

    assign rx_next = {rx_shift[DATA_W-2:0], mosi_s};

    always_ff @(posedge Pclk or negedge Preset_n) begin
        if (!Preset_n) begin
            state      <= IDLE;
            cpol       <= 1'b0;
            cpha       <= 1'b0;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            complete_d <= 1'b0;
            abort      <= 1'b0;
        end else begin
            abort      <= 1'b0;
            complete_d <= 1'b0;
            if (state == IDLE) begin
                if (cs_fall) begin
                    state    <= ACTIVE;
                    cpol     <= mode[1];
                    cpha     <= mode[0];
                    bit_cnt  <= '0;
                    rx_shift <= '0;
                end
            end else if (cs_rise) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                rx_shift <= '0;
                abort    <= (bit_cnt != '0);
            end else if (sample_now) begin
                rx_shift <= rx_next;
                if (bit_cnt == LAST) begin
                    bit_cnt    <= '0;
                    complete_d <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Pclk or negedge Preset_n) begin
        if (!Preset_n) begin
            tx_shift <= '0;
        end else if (word_start) begin
            tx_shift <= tx_full ? tx_buf : '0;
        end else if (shift_now) begin
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
        end else if ((state == ACTIVE) && cs_rise) begin
            tx_shift <= '0;
        end
    end

    // A word start empties the buffer, so a tx_load in that same cycle refills it.
    always_ff @(posedge Pclk or negedge Preset_n) begin
        if (!Preset_n) begin
            tx_buf   <= '0;
            tx_full  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (word_start) begin
                underrun <= ~tx_full;
                tx_full  <= tx_load;
                if (tx_load) tx_buf <= tx_data;
            end else if (tx_load && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge Pclk or negedge Preset_n) begin
        if (!Preset_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (complete_now) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
            end else if (rx_read) begin
                rx_valid <= 1'b0;
            end
            if (complete_now && rx_valid && !rx_read) begin
                overrun <= 1'b1;
            end else if (rx_read) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy     = (state == ACTIVE);
    assign miso_oe  = (state == ACTIVE);
    assign miso     = (state == ACTIVE) && tx_shift[DATA_W-1];
    assign tx_ready = ~tx_full;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a table of single-word frames in every mode,
// then hand-written sequences for underrun, overrun, abort and mid-frame reset.
module tb_spi_slave;

    localparam int DATA_W = 8;
    localparam int HALF   = 80;   // sclk half period in ns; Pclk period is 10 ns

    logic              Pclk, Preset_n;
    logic [1:0]        mode;
    logic              sclk, cs, mosi;
    logic              miso, miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load, tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid, rx_read;
    logic              overrun, underrun, abort, busy;

    int tests_run = 0;
    int tests_failed = 0;
    int stab_err = 0;
    int und_cnt = 0;
    int ab_cnt = 0;

    spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .Pclk(Pclk), .Preset_n(Preset_n), .mode(mode), .sclk(sclk), .cs(cs),
        .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data),
        .tx_load(tx_load), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_read(rx_read), .overrun(overrun),
        .underrun(underrun), .abort(abort), .busy(busy)
    );

    // Clock edges fall on odd 5 ns marks; stimulus and sampling use multiples of 10 ns.
    initial Pclk = 1'b0;
    always #5 Pclk = ~Pclk;

    // Pulse counters: each single-cycle pulse is seen high on exactly one rising edge.
    always @(posedge Pclk) begin
        if (underrun) und_cnt++;
        if (abort)    ab_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_tx(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        #10;
        tx_load = 1'b0;
        #10;
    endtask

    task automatic pulse_read();
        rx_read = 1'b1;
        #10;
        rx_read = 1'b0;
        #10;
    endtask

    task automatic start_frame(input logic [1:0] m);
        sclk = m[1];
        mode = m;
        #100;
        cs = 1'b0;
        #100;
    endtask

    task automatic end_frame();
        #HALF;
        cs = 1'b1;
        #200;
    endtask

    // Master side: drives mosi MSB first and captures miso at the master's sample edge.
    task automatic xfer(input logic [1:0] m, input logic [7:0] mo, input int nbits,
                        output logic [7:0] got);
        got = '0;
        for (int k = 0; k < nbits; k++) begin
            if (!m[0]) begin
                mosi = mo[7-k];
                #HALF;
                got[7-k] = miso;
                sclk = ~m[1];
                #HALF;
                sclk = m[1];
            end else begin
                sclk = ~m[1];
                mosi = mo[7-k];
                #HALF;
                got[7-k] = miso;
                sclk = m[1];
                #HALF;
                if (k < nbits - 1 && miso !== got[7-k]) stab_err++;
            end
        end
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] tx;
        bit         use_extra;
        logic [7:0] extra;
        logic [7:0] mo;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [7:0] got, g1, g2;
        int und0, und1, ab0, stab0;

        vecs[0] = '{mode: 2'd0, tx: 8'hA5, use_extra: 1'b1, extra: 8'hFF, mo: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C};
        vecs[1] = '{mode: 2'd3, tx: 8'hA5, use_extra: 1'b0, extra: 8'h00, mo: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C};
        vecs[2] = '{mode: 2'd1, tx: 8'h0F, use_extra: 1'b0, extra: 8'h00, mo: 8'hF0, exp_miso: 8'h0F, exp_rx: 8'hF0};
        vecs[3] = '{mode: 2'd2, tx: 8'h81, use_extra: 1'b1, extra: 8'h18, mo: 8'h7E, exp_miso: 8'h81, exp_rx: 8'h7E};

        Preset_n = 1'b0;
        mode = 2'd0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_load = 1'b0; rx_read = 1'b0;
        #50;
        check("reset_miso",     miso,     0);
        check("reset_miso_oe",  miso_oe,  0);
        check("reset_busy",     busy,     0);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data",  rx_data,  0);
        check("reset_flags",    {overrun, underrun, abort}, 0);
        Preset_n = 1'b1;
        #100;

        for (int v = 0; v < 4; v++) begin
            load_tx(vecs[v].tx);
            check($sformatf("v%0d_tx_ready_full", v), tx_ready, 0);
            if (vecs[v].use_extra) load_tx(vecs[v].extra);
            stab0 = stab_err;
            start_frame(vecs[v].mode);
            check($sformatf("v%0d_busy", v), busy, 1);
            check($sformatf("v%0d_miso_oe", v), miso_oe, 1);
            check($sformatf("v%0d_tx_ready_after_start", v), tx_ready, 1);
            xfer(vecs[v].mode, vecs[v].mo, 8, got);
            end_frame();
            check($sformatf("v%0d_miso_word", v), got, vecs[v].exp_miso);
            check($sformatf("v%0d_rx_data", v), rx_data, vecs[v].exp_rx);
            check($sformatf("v%0d_rx_valid", v), rx_valid, 1);
            check($sformatf("v%0d_idle_outputs", v), {busy, miso_oe, miso}, 0);
            if (vecs[v].mode[0]) check($sformatf("v%0d_miso_stable_on_trailing", v), stab_err - stab0, 0);
            pulse_read();
            check($sformatf("v%0d_rx_valid_cleared", v), rx_valid, 0);
        end

        // Mode 1 two-word frame, buffer filled only for the first word.
        load_tx(8'h5A);
        start_frame(2'd1);
        und0 = und_cnt;
        xfer(2'd1, 8'hA1, 8, g1);
        und1 = und_cnt;
        xfer(2'd1, 8'hB2, 8, g2);
        end_frame();
        check("two_word_miso1", g1, 8'h5A);
        check("two_word_underrun_once", und1 - und0, 1);
        check("two_word_miso2", g2, 8'h00);
        check("two_word_rx_data", rx_data, 8'hB2);
        pulse_read();

        // Two words without a read in between: the second overwrites and sets overrun.
        start_frame(2'd0);
        xfer(2'd0, 8'h11, 8, g1);
        xfer(2'd0, 8'h22, 8, g2);
        end_frame();
        check("overrun_rx_data", rx_data, 8'h22);
        check("overrun_set", overrun, 1);
        check("overrun_rx_valid", rx_valid, 1);
        pulse_read();
        check("overrun_read_valid", rx_valid, 0);
        check("overrun_read_clear", overrun, 0);

        // Abort after 5 bits with a word already waiting.
        start_frame(2'd0);
        xfer(2'd0, 8'h96, 8, got);
        end_frame();
        ab0 = ab_cnt;
        start_frame(2'd0);
        xfer(2'd0, 8'hFF, 5, got);
        end_frame();
        check("abort_pulse", ab_cnt - ab0, 1);
        check("abort_rx_valid", rx_valid, 1);
        check("abort_rx_data", rx_data, 8'h96);
        check("abort_no_overrun", overrun, 0);
        pulse_read();
        start_frame(2'd0);
        xfer(2'd0, 8'hC3, 8, got);
        end_frame();
        check("after_abort_rx_data", rx_data, 8'hC3);
        check("after_abort_rx_valid", rx_valid, 1);

        // Reset in the middle of a word, with cs held low across the release.
        load_tx(8'h77);
        start_frame(2'd0);
        load_tx(8'h66);
        xfer(2'd0, 8'hE7, 3, got);
        #3;
        Preset_n = 1'b0;
        #1;
        check("midreset_miso",     miso,     0);
        check("midreset_busy_oe",  {busy, miso_oe}, 0);
        check("midreset_tx_ready", tx_ready, 1);
        check("midreset_rx",       {rx_valid, rx_data}, 0);
        check("midreset_flags",    {overrun, underrun, abort}, 0);
        #6;
        #20;
        Preset_n = 1'b1;
        #100;
        xfer(2'd0, 8'h5C, 8, got);
        #200;
        check("post_reset_rx_valid", rx_valid, 0);
        check("post_reset_busy", busy, 0);
        cs = 1'b1;
        #200;

        // A fresh falling edge after reset starts a normal frame again.
        load_tx(8'h3A);
        start_frame(2'd0);
        xfer(2'd0, 8'h4B, 8, got);
        end_frame();
        check("post_reset_frame_miso", got, 8'h3A);
        check("post_reset_frame_rx", rx_data, 8'h4B);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
